// File: rtl/fft_stage_ctrl.sv
// rtl/fft_stage_ctrl.sv - per-stage address/mux sequencer for the 32-point memory-based FFT
//
// Runs one FFT stage at a time across 4 banks x 2^ADDRSIZE words: generates
// bank read addresses, write addresses delayed by the read + PE latency, the
// bank/PE mux selects and the write strobe, then raises stage_done until the
// top-level FSM drops en_stage.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   ld_data      RAM load in progress; aborts any stage, forces load mode
//   en_stage     start / hold request from the top-level FSM
//   stage_num    stage to run, latched at start (>= NUMSTAGES is invalid)
//   m0_s         bank input select (0 = external data, 1 = PE results)
//   m1_s         PE input permutation select
//   m2_s         write-back select (1 = straight, 0 = halves swapped)
//   m3_s         write strobe, high exactly when w_addr_* are valid
//   r_addr_0_1   read address, banks 0/1
//   r_addr_2_3   read address, banks 2/3
//   w_addr_0_1   write address, banks 0/1
//   w_addr_2_3   write address, banks 2/3
//   stage_done   stage complete, held until en_stage falls

module fft_stage_ctrl #(
  parameter int NUMSTAGES = 5,
  parameter int ADDRSIZE  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_data,
  input  logic                en_stage,
  input  logic [2:0]          stage_num,
  output logic                m0_s,
  output logic [1:0]          m1_s,
  output logic                m2_s,
  output logic                m3_s,
  output logic [ADDRSIZE-1:0] r_addr_0_1,
  output logic [ADDRSIZE-1:0] r_addr_2_3,
  output logic [ADDRSIZE-1:0] w_addr_0_1,
  output logic [ADDRSIZE-1:0] w_addr_2_3,
  output logic                stage_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  localparam logic [ADDRSIZE-1:0] ADDR_ONE = {{(ADDRSIZE-1){1'b0}}, 1'b1};

  state_t              state_q;
  logic [ADDRSIZE-1:0] k_q, k_d;
  logic [ADDRSIZE-1:0] mask_q;
  logic                drain_q;
  // Middle stage of the write pipeline: the read address one cycle later,
  // lined up with the RAM output feeding the PE.
  logic [ADDRSIZE-1:0] p01_q, p23_q;
  logic                pv_q;
  logic [1:0]          m1_q;
  logic                m2_q, m3_q, done_q;
  logic [ADDRSIZE-1:0] r01_q, r23_q, w01_q, w23_q;

  // Partner-bank XOR mask: 0 for the first two stages, then the butterfly
  // span halves each stage (4, 2, 1 for the 8-word banks).
  function automatic logic [ADDRSIZE-1:0] mask_f(input logic [2:0] s);
    logic [ADDRSIZE-1:0] m;
    m = '0;
    if (s >= 3'd2) m = ADDR_ONE << (ADDRSIZE + 1 - int'(s));
    return m;
  endfunction

  assign k_d = k_q + ADDR_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      mask_q  <= '0;
      drain_q <= 1'b0;
      p01_q   <= '0;
      p23_q   <= '0;
      pv_q    <= 1'b0;
      m1_q    <= 2'b00;
      m2_q    <= 1'b0;
      m3_q    <= 1'b0;
      done_q  <= 1'b0;
      r01_q   <= '0;
      r23_q   <= '0;
      w01_q   <= '0;
      w23_q   <= '0;
    end else if (ld_data) begin
      // Load mode: drop everything in flight, addresses keep their values.
      state_q <= IDLE;
      k_q     <= '0;
      drain_q <= 1'b0;
      pv_q    <= 1'b0;
      m3_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // Write pipeline: read address -> p stage -> write address.
      pv_q  <= (state_q == RUN);
      p01_q <= r01_q;
      p23_q <= r23_q;
      m3_q  <= pv_q;
      if (pv_q) begin
        w01_q <= p01_q;
        w23_q <= p23_q;
      end

      case (state_q)
        IDLE: begin
          if (en_stage) begin
            if (int'(stage_num) >= NUMSTAGES) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              k_q     <= '0;
              mask_q  <= mask_f(stage_num);
              r01_q   <= '0;
              r23_q   <= mask_f(stage_num);
              case (stage_num)
                3'd0:    begin m1_q <= 2'b10; m2_q <= 1'b1; end
                3'd1:    begin m1_q <= 2'b00; m2_q <= 1'b1; end
                default: begin m1_q <= 2'b01; m2_q <= 1'b0; end
              endcase
            end
          end
        end
        RUN: begin
          if (k_q == '1) begin
            state_q <= DRAIN;
            drain_q <= 1'b0;
          end else begin
            k_q   <= k_d;
            r01_q <= k_d;
            r23_q <= k_d ^ mask_q;
          end
        end
        DRAIN: begin
          if (drain_q) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end else begin
            drain_q <= 1'b1;
          end
        end
        FINISH: begin
          if (!en_stage) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Load must steer external data into the banks without waiting for a clock.
  assign m0_s       = (state_q != IDLE) && !ld_data;
  assign m1_s       = m1_q;
  assign m2_s       = m2_q;
  assign m3_s       = m3_q;
  assign r_addr_0_1 = r01_q;
  assign r_addr_2_3 = r23_q;
  assign w_addr_0_1 = w01_q;
  assign w_addr_2_3 = w23_q;
  assign stage_done = done_q;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// tb/tb_fft_stage_ctrl.sv - scoreboard bench for fft_stage_ctrl

module tb_fft_stage_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ld_data = 1'b0;
  logic       en_stage = 1'b0;
  logic [2:0] stage_num = 3'd0;
  logic       m0_s, m2_s, m3_s, stage_done;
  logic [1:0] m1_s;
  logic [2:0] r_addr_0_1, r_addr_2_3, w_addr_0_1, w_addr_2_3;

  int n_tests = 0;
  int n_fail  = 0;
  int wq[$];

  fft_stage_ctrl #(.NUMSTAGES(5), .ADDRSIZE(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_data    (ld_data),
    .en_stage   (en_stage),
    .stage_num  (stage_num),
    .m0_s       (m0_s),
    .m1_s       (m1_s),
    .m2_s       (m2_s),
    .m3_s       (m3_s),
    .r_addr_0_1 (r_addr_0_1),
    .r_addr_2_3 (r_addr_2_3),
    .w_addr_0_1 (w_addr_0_1),
    .w_addr_2_3 (w_addr_2_3),
    .stage_done (stage_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mask_of(input int s);
    case (s)
      2:       return 4;
      3:       return 2;
      4:       return 1;
      default: return 0;
    endcase
  endfunction

  task automatic push_writes(input int s, input int n);
    for (int i = 0; i < n; i++) wq.push_back((i << 8) | (i ^ mask_of(s)));
  endtask

  // Every strobed write must match the next expected write, in order.
  always @(negedge clk) begin : mon
    int e;
    if (rst_n && m3_s) begin
      if (wq.size() == 0) begin
        check("unexpected_write", int'(m3_s), 0);
      end else begin
        e = wq.pop_front();
        check("w_addr", (int'(w_addr_0_1) << 8) | int'(w_addr_2_3), e);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_m0"}, int'(m0_s), 0);
    check({tag, "_m1"}, int'(m1_s), 0);
    check({tag, "_m2"}, int'(m2_s), 0);
    check({tag, "_m3"}, int'(m3_s), 0);
    check({tag, "_r01"}, int'(r_addr_0_1), 0);
    check({tag, "_r23"}, int'(r_addr_2_3), 0);
    check({tag, "_w01"}, int'(w_addr_0_1), 0);
    check({tag, "_w23"}, int'(w_addr_2_3), 0);
    check({tag, "_done"}, int'(stage_done), 0);
  endtask

  // Start stage s and check every cycle after E0..E(last_c).
  task automatic run_stage(input int s, input int last_c);
    int rs;
    @(posedge clk); #1;
    stage_num = 3'(s);
    en_stage  = 1'b1;
    for (int c = 0; c <= last_c; c++) begin
      @(posedge clk);
      @(negedge clk);
      rs = (c > 7) ? 7 : c;
      check("r01", int'(r_addr_0_1), rs);
      check("r23", int'(r_addr_2_3), rs ^ mask_of(s));
      check("m3", int'(m3_s), (c >= 2 && c <= 9) ? 1 : 0);
      check("done", int'(stage_done), (c == 10) ? 1 : 0);
      check("m0", int'(m0_s), 1);
      if (c == 0) begin
        check("m1", int'(m1_s), (s == 0) ? 2 : (s == 1) ? 0 : 1);
        check("m2", int'(m2_s), (s <= 1) ? 1 : 0);
      end
    end
  endtask

  task automatic finish_stage();
    @(posedge clk); #1;
    en_stage = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("done_clear", int'(stage_done), 0);
    check("idle_m0", int'(m0_s), 0);
  endtask

  initial begin
    #2;
    check_all_zero("reset");
    #10;
    rst_n = 1'b1;

    // Stage 0: straight addresses, m1=10, m2=1.
    push_writes(0, 8);
    run_stage(0, 10);
    finish_stage();

    // Invalid stage: straight to FINISH, selects and addresses untouched.
    @(posedge clk); #1;
    stage_num = 3'd6;
    en_stage  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("inv_done", int'(stage_done), 1);
    check("inv_m1", int'(m1_s), 2);
    check("inv_m2", int'(m2_s), 1);
    check("inv_r01", int'(r_addr_0_1), 7);
    check("inv_r23", int'(r_addr_2_3), 7);
    check("inv_m0", int'(m0_s), 1);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("inv_m3", int'(m3_s), 0);
      check("inv_hold", int'(stage_done), 1);
    end
    finish_stage();

    // Stage 3, then hold en_stage high: done stays, no new reads or writes.
    push_writes(3, 8);
    run_stage(3, 10);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_done", int'(stage_done), 1);
      check("hold_r01", int'(r_addr_0_1), 7);
      check("hold_r23", int'(r_addr_2_3), 5);
      check("hold_m3", int'(m3_s), 0);
    end
    finish_stage();

    // Stage 4, mask 1.
    push_writes(4, 8);
    run_stage(4, 10);
    finish_stage();

    // Abort stage 2 at RUN k=4: only steps 0..2 get written.
    push_writes(2, 3);
    run_stage(2, 4);
    ld_data  = 1'b1;
    en_stage = 1'b0;
    #1;
    check("abort_m0_comb", int'(m0_s), 0);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("abort_m3", int'(m3_s), 0);
      check("abort_done", int'(stage_done), 0);
      check("abort_m0", int'(m0_s), 0);
    end
    @(posedge clk); #1;
    ld_data = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_idle_m0", int'(m0_s), 0);
    check("abort_idle_m3", int'(m3_s), 0);

    // Stage 1 with async reset in DRAIN (after E8, write of step 6 visible).
    push_writes(1, 7);
    run_stage(1, 8);
    #1;
    rst_n    = 1'b0;
    en_stage = 1'b0;
    #1;
    check_all_zero("areset");
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      check("post_rst_m3", int'(m3_s), 0);
      check("post_rst_done", int'(stage_done), 0);
      check("post_rst_m0", int'(m0_s), 0);
    end

    check("sb_empty", wq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_stage_ctrl.md
# fft_stage_ctrl

Per-stage sequencer for the 32-point, 5-stage memory-based FFT. It sits between the FFT top-level state machine and the datapath of 4 RAM banks × 8 words, the 4-input/4-output PE and the bank/PE muxes. For each stage it generates the bank read/write addresses, the mux selects and a write strobe, then reports completion with a level handshake.

## Interface
- NUMSTAGES, default 5: number of FFT stages; `stage_num` ≥ NUMSTAGES is invalid.
- ADDRSIZE, default 3: bank address width; 2^ADDRSIZE = 8 words per bank.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- ld_data  input  1  RAM load in progress; forces load mode and aborts any stage.
- en_stage  input  1  start/hold request from the top-level FSM.
- stage_num  input  3  stage to run (0..4); latched at start.
- m0_s  output  1  bank input select: 0 = external data_in, 1 = PE results.
- m1_s  output  2  PE input permutation (in0..in3):
  - 00 = b0,b1,b2,b3
  - 01 = b2,b0,b3,b1
  - 10 = b0,b2,b1,b3
- m2_s  output  1  write-back select: 1 = straight (bank i ← pe_out i); 0 = halves swapped (bank0/1 ← pe_out2/3, bank2/3 ← pe_out0/1).
- m3_s  output  1  write strobe; high exactly when w_addr_* carry a valid write.
- r_addr_0_1, r_addr_2_3  output  ADDRSIZE  read addresses for banks 0/1 and banks 2/3.
- w_addr_0_1, w_addr_2_3  output  ADDRSIZE  write addresses for banks 0/1 and banks 2/3.
- stage_done  output  1  stage complete; held until en_stage falls.

## Operation
- FSM states: IDLE, RUN, DRAIN, FINISH.
  - IDLE: on `en_stage`=1 and `ld_data`=0, latch `stage_num` as s, clear counter k, go to RUN.
  - RUN: 8 cycles, k = 0..7; then DRAIN.
  - DRAIN: 2 cycles; then FINISH.
  - FINISH: `stage_done`=1; when `en_stage`=0, go to IDLE and clear `stage_done`.
- Per-stage constants, held from RUN entry until the next start:
  - s=0: m1_s=10, m2_s=1
  - s=1: m1_s=00, m2_s=1
  - s=2..4: m1_s=01, m2_s=0
- Address mask: mask(s) = 0, 0, 4, 2, 1 for s = 0..4.
- Read addresses in RUN step k:
  - r_addr_0_1 = k
  - r_addr_2_3 = k XOR mask(s)
  - Each bank address is therefore visited exactly once per stage.
- Write pipeline: w_addr_0_1 and w_addr_2_3 equal the step-k read addresses delayed 2 cycles (1 cycle RAM read + 1 cycle PE/register). `m3_s`=1 on exactly those 8 cycles.
- m0_s is 1 in RUN, DRAIN and FINISH, and 0 in IDLE or whenever `ld_data`=1.
- Invalid `stage_num` (≥ NUMSTAGES): go directly IDLE → FINISH. No read sequence, `m3_s` never asserts, m1_s/m2_s are unchanged.
- `ld_data`=1 in any state: next state is IDLE; m3_s=0, stage_done=0, counters cleared. Any in-flight writes are discarded.
- Outside RUN/DRAIN, the address outputs hold their last values.

## Timing
- All outputs are registered except m0_s, which is combinationally forced to 0 by ld_data.
- Reset values: all address outputs 0; m0_s=0, m1_s=00, m2_s=0, m3_s=0, stage_done=0; state IDLE.
- Let E0 be the edge on which IDLE samples `en_stage`=1:
  - After E0: r_addr = step 0; m1_s/m2_s take their stage values.
  - After E(k): r_addr = step k, for k = 0..7.
  - After E(k+2): w_addr = step k and m3_s=1, for k = 0..7 (i.e. E2..E9).
  - After E10: stage_done=1 and m3_s=0. Stage latency is 10 clocks.
- `en_stage` falling in RUN/DRAIN is ignored; the stage completes.
- `stage_done` clears on the first edge that samples `en_stage`=0 in FINISH. A fresh start requires one IDLE cycle with `en_stage`=1.
- Asynchronous `rst_n` assertion mid-stage forces reset values immediately; no write strobes follow.

## Test plan
- Reset then stage 0: rst_n low → all outputs 0. Start s=0 → r_addr_0_1 = r_addr_2_3 = 0..7 on E0..E7; m1_s=10, m2_s=1; m3_s high E2..E9 with w_addr 0..7; stage_done at E10.
- Stage 3: r_addr_2_3 sequence = 2,3,0,1,6,7,4,5 while r_addr_0_1 = 0..7; m1_s=01, m2_s=0; w_addr_2_3 repeats that sequence 2 cycles later.
- Handshake: hold en_stage=1 after stage_done → stage_done stays 1 and no new reads occur. Drop en_stage → stage_done=0 next edge. Raise en_stage with stage_num=4 → new stage runs with mask 1.
- Abort: ld_data=1 at RUN k=4 → next edge IDLE; m0_s=0 immediately; m3_s=0 and no further writes; stage_done stays 0.
- Invalid stage: stage_num=6 → stage_done=1 after E0; m3_s never asserts; m1_s/m2_s keep their previous values.
- Async reset during DRAIN → outputs return to reset values without waiting for a clock edge.
